// File: rtl/triangle_stimulus_gen_pkg.sv
// Shared definitions for the triangle stimulus generator: state encoding
// and default bus widths matching the peak_detection data path.
package tsg_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_HOLD_W   = 16;
    localparam int DEF_PERIOD_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RISE = 2'd1;
    localparam state_t ST_FALL = 2'd2;

endpackage

// File: rtl/triangle_stimulus_gen_if.sv
// Control, configuration and sample bus of the triangle stimulus generator.
// The master drives start/config and observes the samples; the slave is the generator.
interface triangle_stimulus_gen_if #(
    parameter int WIDTH    = 16,
    parameter int HOLD_W   = 16,
    parameter int PERIOD_W = 8
);
    logic                start;
    logic                enable;
    logic [HOLD_W-1:0]   hold_cycles;
    logic [WIDTH-1:0]    step;
    logic [WIDTH-1:0]    low_limit;
    logic [WIDTH-1:0]    high_limit;
    logic [PERIOD_W-1:0] num_periods;

    logic [WIDTH-1:0]    output_data;
    logic                sample_strobe;
    logic                peak_flag;
    logic                trough_flag;
    logic                busy;
    logic                done;
    logic                config_error;

    modport master (
        output start, enable, hold_cycles, step, low_limit, high_limit, num_periods,
        input  output_data, sample_strobe, peak_flag, trough_flag, busy, done, config_error
    );

    modport slave (
        input  start, enable, hold_cycles, step, low_limit, high_limit, num_periods,
        output output_data, sample_strobe, peak_flag, trough_flag, busy, done, config_error
    );

endinterface

// File: rtl/triangle_stimulus_gen_hold_timer.sv
// Programmable prescaler: while run is high, tick fires once every
// max(hold_cycles,1) clocks; clear restarts the interval.
module hold_timer #(
    parameter int HOLD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              clear,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic              tick
);

    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] cnt_d;
    logic [HOLD_W-1:0] last_cnt;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        last_cnt = '0;
        if (hold_cycles != '0) begin
            last_cnt = hold_cycles - HOLD_W'(1);
        end
        tick  = run && (cnt_q == last_cnt);
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + HOLD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/triangle_stimulus_gen.sv
// Triangle-wave sample source: ramps low_limit -> high_limit -> low_limit in
// fixed steps, each value held a programmable number of clocks, for N periods.
module triangle_stimulus_gen
    import tsg_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic clk,
    input  logic reset,
    triangle_stimulus_gen_if.slave bus
);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    value_q, value_d;
    logic                strobe_q, strobe_d;
    logic                peak_q, peak_d;
    logic                trough_q, trough_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic [PERIOD_W-1:0] period_q, period_d;

    logic [HOLD_W-1:0]   hold_cfg_q, hold_cfg_d;
    logic [WIDTH-1:0]    step_q, step_d;
    logic [WIDTH-1:0]    low_q, low_d;
    logic [WIDTH-1:0]    high_q, high_d;
    logic [PERIOD_W-1:0] nper_q, nper_d;

    logic                start_ok;
    logic                accept;
    logic                run;
    logic                tick;
    logic [WIDTH:0]      sum;
    logic                at_peak;
    logic                at_trough;
    logic [PERIOD_W-1:0] period_inc;
    logic                last_period;

    always_comb begin
        start_ok    = bus.start && (bus.step != '0) && (bus.low_limit < bus.high_limit);
        accept      = (state_q == ST_IDLE) && start_ok;
        run         = (state_q != ST_IDLE) && bus.enable;
        sum         = {1'b0, value_q} + {1'b0, step_q};
        at_peak     = sum >= {1'b0, high_q};
        // value_q never drops below low_q while falling, so the difference cannot wrap
        at_trough   = (value_q - low_q) <= step_q;
        period_inc  = period_q + PERIOD_W'(1);
        last_period = (nper_q != '0) && (period_inc == nper_q);
    end

    hold_timer #(.HOLD_W(HOLD_W)) u_hold_timer (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .clear       (accept),
        .hold_cycles (hold_cfg_q),
        .tick        (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RISE;
            ST_RISE: if (tick && at_peak) state_d = ST_FALL;
            ST_FALL: if (tick && at_trough) state_d = last_period ? ST_IDLE : ST_RISE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        value_d    = value_q;
        strobe_d   = 1'b0;
        peak_d     = 1'b0;
        trough_d   = 1'b0;
        done_d     = 1'b0;
        cfg_err_d  = 1'b0;
        period_d   = period_q;
        hold_cfg_d = hold_cfg_q;
        step_d     = step_q;
        low_d      = low_q;
        high_d     = high_q;
        nper_d     = nper_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    hold_cfg_d = bus.hold_cycles;
                    step_d     = bus.step;
                    low_d      = bus.low_limit;
                    high_d     = bus.high_limit;
                    nper_d     = bus.num_periods;
                    value_d    = bus.low_limit;
                    strobe_d   = 1'b1;
                    period_d   = '0;
                end else if (bus.start) begin
                    cfg_err_d  = 1'b1;
                end
            end
            ST_RISE: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (at_peak) begin
                        value_d = high_q;
                        peak_d  = 1'b1;
                    end else begin
                        value_d = sum[WIDTH-1:0];
                    end
                end
            end
            ST_FALL: begin
                if (tick) begin
                    strobe_d = 1'b1;
                    if (at_trough) begin
                        value_d  = low_q;
                        trough_d = 1'b1;
                        period_d = period_inc;
                        done_d   = last_period;
                    end else begin
                        value_d  = value_q - step_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q    <= '0;
            strobe_q   <= 1'b0;
            peak_q     <= 1'b0;
            trough_q   <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            period_q   <= '0;
            hold_cfg_q <= '0;
            step_q     <= '0;
            low_q      <= '0;
            high_q     <= '0;
            nper_q     <= '0;
        end else begin
            value_q    <= value_d;
            strobe_q   <= strobe_d;
            peak_q     <= peak_d;
            trough_q   <= trough_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            period_q   <= period_d;
            hold_cfg_q <= hold_cfg_d;
            step_q     <= step_d;
            low_q      <= low_d;
            high_q     <= high_d;
            nper_q     <= nper_d;
        end
    end

    assign bus.output_data   = value_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.peak_flag     = peak_q;
    assign bus.trough_flag   = trough_q;
    assign bus.done          = done_q;
    assign bus.config_error  = cfg_err_q;
    assign bus.busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_triangle_stimulus_gen.sv
// Scoreboard bench for triangle_stimulus_gen: a waveform model fills an expected
// sample queue at start time; a monitor pops and compares on every sample_strobe.
module tb_triangle_stimulus_gen;

    localparam int W  = 16;
    localparam int HW = 16;
    localparam int PW = 8;

    typedef struct {
        int value;
        bit peak;
        bit trough;
        bit done;
        int gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    triangle_stimulus_gen_if #(.WIDTH(W), .HOLD_W(HW), .PERIOD_W(PW)) bus ();

    triangle_stimulus_gen #(.WIDTH(W), .HOLD_W(HW), .PERIOD_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   cfg_err_exp = 0;
    int   cyc = 0;
    int   trough_seen = 0;
    int   done_seen = 0;
    int   done_cyc = -1;
    int   start_cyc = 0;
    bit   rand_en = 1'b0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected sample sequence built directly from the waveform rules.
    task automatic push(input int v, input bit pk, input bit tr, input bit dn, input int gap);
        exp_t e;
        e.value = v; e.peak = pk; e.trough = tr; e.done = dn; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_run(input int lo, input int hi, input int st, input int hold,
                            input int np, input int periods, input bit extra_rise);
        int h;
        int v;
        h = (hold == 0) ? 1 : hold;
        v = lo;
        push(v, 0, 0, 0, 0);
        for (int p = 0; p < periods + (extra_rise ? 1 : 0); p++) begin
            while (v != hi) begin
                v = (v + st >= hi) ? hi : v + st;
                push(v, v == hi, 0, 0, h);
            end
            if (p == periods) break;
            while (v != lo) begin
                v = (v - lo <= st) ? lo : v - st;
                push(v, 0, v == lo, (v == lo) && (np != 0) && (p + 1 == np), h);
            end
        end
    endtask

    // Monitor: sample at posedge for pre-edge context, compare 1 time unit later.
    logic mon_en, mon_run, mon_rst;
    int   gap_cnt = 0;
    exp_t mon_e;

    always @(posedge clk) begin
        cyc++;
        mon_en  = bus.enable;
        mon_run = bus.busy;
        mon_rst = reset;
        #1;
        if (mon_rst || reset) begin
            gap_cnt = 0;
        end else begin
            if (mon_en && mon_run) gap_cnt++;
            if (bus.sample_strobe) begin
                check(exp_q.size() > 0, "strobe_expected", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check(bus.output_data == mon_e.value, "sample_value", bus.output_data, mon_e.value);
                    check({bus.peak_flag, bus.trough_flag, bus.done} == {mon_e.peak, mon_e.trough, mon_e.done},
                          "flags_pk_tr_dn", {bus.peak_flag, bus.trough_flag, bus.done},
                          {mon_e.peak, mon_e.trough, mon_e.done});
                    if (mon_e.gap != 0)
                        check(gap_cnt == mon_e.gap, "hold_interval", gap_cnt, mon_e.gap);
                    check(mon_en == 1'b1, "strobe_while_paused", mon_en, 1);
                    check(bus.busy == !mon_e.done, "busy_after_sample", bus.busy, !mon_e.done);
                end
                gap_cnt = 0;
                if (bus.trough_flag) trough_seen++;
                if (bus.done) begin
                    done_seen++;
                    done_cyc = cyc;
                end
            end else begin
                check(!(bus.peak_flag || bus.trough_flag || bus.done), "flag_without_strobe",
                      {bus.peak_flag, bus.trough_flag, bus.done}, 0);
            end
            if (bus.config_error) begin
                check(cfg_err_exp > 0, "unexpected_config_error", 1, cfg_err_exp);
                if (cfg_err_exp > 0) cfg_err_exp--;
            end
        end
    end

    task automatic do_start(input int lo, input int hi, input int st, input int hold, input int np);
        @(negedge clk);
        bus.low_limit   = W'(lo);
        bus.high_limit  = W'(hi);
        bus.step        = W'(st);
        bus.hold_cycles = HW'(hold);
        bus.num_periods = PW'(np);
        bus.enable      = 1'b1;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rand_en) bus.enable = ($urandom % 4) != 0;
            if (done_seen > d0) break;
        end
        bus.enable = 1'b1;
        check(done_seen > d0, "done_timeout", done_seen - d0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check(bus.output_data == '0, {tag, "_output_data"}, bus.output_data, 0);
        check({bus.sample_strobe, bus.peak_flag, bus.trough_flag, bus.done, bus.config_error} == '0,
              {tag, "_pulses"},
              {bus.sample_strobe, bus.peak_flag, bus.trough_flag, bus.done, bus.config_error}, 0);
        check(bus.busy == 1'b0, {tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        int k;
        int prev;
        int snap;
        int t0;
        int d0;
        int lo, hi, st, hold, np;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.enable      = 1'b1;
        bus.hold_cycles = '0;
        bus.step        = '0;
        bus.low_limit   = '0;
        bus.high_limit  = '0;
        bus.num_periods = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Slow ramp: 20 clocks per value, one period
        push_run(0, 19, 1, 20, 1, 1, 0);
        do_start(0, 19, 1, 20, 1);
        k = start_cyc;
        wait_done(2000);
        check(done_cyc - k == 760, "slow_ramp_done_edge", done_cyc - k, 760);
        check(bus.output_data == 0, "slow_ramp_final_value", bus.output_data, 0);

        // Saturating steps at both ends
        push_run(0, 20, 7, 1, 1, 1, 0);
        do_start(0, 20, 7, 1, 1);
        wait_done(200);

        // Rejected starts: equal limits, then zero step
        prev = bus.output_data;
        cfg_err_exp++;
        do_start(5, 5, 3, 1, 1);
        repeat (3) @(negedge clk);
        check(bus.busy == 1'b0, "equal_limits_busy", bus.busy, 0);
        check(bus.output_data == prev, "equal_limits_hold_value", bus.output_data, prev);
        cfg_err_exp++;
        do_start(1, 9, 0, 1, 1);
        repeat (3) @(negedge clk);
        check(bus.busy == 1'b0, "zero_step_busy", bus.busy, 0);
        check(bus.output_data == prev, "zero_step_hold_value", bus.output_data, prev);
        check(cfg_err_exp == 0, "config_error_count", cfg_err_exp, 0);

        // hold_cycles=0 behaves as 1
        push_run(0, 20, 7, 0, 1, 1, 0);
        do_start(0, 20, 7, 0, 1);
        wait_done(200);

        // Pause mid-rise
        push_run(0, 10, 1, 6, 1, 1, 0);
        do_start(0, 10, 1, 6, 1);
        for (int i = 0; i < 1000 && bus.output_data != 3; i++) @(negedge clk);
        check(bus.output_data == 3, "pause_reach_3", bus.output_data, 3);
        repeat (2) @(negedge clk);
        bus.enable = 1'b0;
        snap = bus.output_data;
        repeat (50) @(negedge clk);
        check(bus.output_data == snap, "pause_value_frozen", bus.output_data, snap);
        check(bus.busy == 1'b1, "pause_busy_held", bus.busy, 1);
        bus.enable = 1'b1;
        wait_done(500);

        // Free-run: three full periods, then reset while falling
        t0 = trough_seen;
        d0 = done_seen;
        push_run(2, 9, 3, 8, 0, 3, 1);
        do_start(2, 9, 3, 8, 0);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        check(exp_q.size() == 0, "free_run_progress", exp_q.size(), 0);
        check(trough_seen - t0 == 3, "free_run_troughs", trough_seen - t0, 3);
        check(done_seen == d0, "free_run_no_done", done_seen - d0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;

        // Fresh run after reset, two periods
        push_run(3, 50, 4, 2, 2, 2, 0);
        do_start(3, 50, 4, 2, 2);
        wait_done(2000);

        // Near full scale, with a start pulse while busy that must be ignored
        push_run(16'hFFF0, 16'hFFFF, 16'h10, 3, 2, 2, 0);
        do_start(16'hFFF0, 16'hFFFF, 16'h10, 3, 2);
        repeat (4) @(negedge clk);
        bus.low_limit   = '0;
        bus.high_limit  = 16'd100;
        bus.step        = 16'd1;
        bus.hold_cycles = 16'd1;
        bus.num_periods = 8'd1;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(500);

        // Randomised configurations with random pauses
        for (int r = 0; r < 6; r++) begin
            lo   = $urandom_range(0, 65000);
            hi   = lo + $urandom_range(1, 200);
            st   = $urandom_range(1, 60);
            hold = $urandom_range(0, 3);
            np   = $urandom_range(1, 2);
            push_run(lo, hi, st, hold, np, np, 0);
            do_start(lo, hi, st, hold, np);
            rand_en = 1'b1;
            wait_done(20000);
            rand_en = 1'b0;
        end

        repeat (3) @(negedge clk);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        check(cfg_err_exp == 0, "config_error_drained", cfg_err_exp, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/triangle_stimulus_gen.md
Name: triangle_stimulus_gen

Overview:
- Synthesizable triangle-wave sample source that drives the input_data bus of peak_detection.
- Replaces hand-written testbench ramps with a programmable on-chip stimulus for hardware-in-loop checking of the detector.
- Each sample value is held for a programmable number of clocks.
- The waveform ramps from low_limit up to high_limit in fixed steps, then ramps back down.
- Runs for N periods, or free-runs when num_periods is 0.

Parameters:
- WIDTH, 16, sample width; matches the peak_detection data bus.
- HOLD_W, 16, width of the hold_cycles counter.
- PERIOD_W, 8, width of the period counter.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle pulse; latches config and begins generation
- enable  input  1  0 = pause: state, counters and output frozen
- hold_cycles  input  HOLD_W  clocks each value is held; 0 is treated as 1
- step  input  WIDTH  magnitude of each increment/decrement
- low_limit  input  WIDTH  trough value (unsigned)
- high_limit  input  WIDTH  peak value (unsigned)
- num_periods  input  PERIOD_W  periods to generate; 0 = run forever
- output_data  output  WIDTH  current sample
- sample_strobe  output  1  1-cycle pulse in the cycle output_data takes a new value
- peak_flag  output  1  1-cycle pulse when output_data reaches high_limit
- trough_flag  output  1  1-cycle pulse when output_data returns to low_limit
- busy  output  1  high while in RISE or FALL
- done  output  1  1-cycle pulse on completion of the final period
- config_error  output  1  1-cycle pulse when start is rejected

Behaviour:
- Reset (asynchronous, effective at any time including mid-run): state=IDLE, all counters 0, output_data=0, all flags/strobes/busy=0, latched config=0.
- States: IDLE, RISE, FALL.
- IDLE:
  - start=1 with step!=0 and low_limit<high_limit: latch all config inputs. Next cycle: output_data=low_limit, sample_strobe=1, busy=1, hold_cnt=0, period_cnt=0, state=RISE.
  - start=1 with an invalid config: config_error=1 next cycle, stay IDLE, output_data unchanged.
- start is ignored while busy. Config input changes take effect only at the next accepted start.
- Hold timer: in RISE/FALL with enable=1, hold_cnt increments each clock. At hold_cnt==max(hold_cycles,1)-1 it wraps to 0 and issues an update. Every value is therefore held exactly max(hold_cycles,1) clocks. With enable=0 nothing advances and all pulses are 0.
- Update in RISE:
  - sum = value+step, computed in WIDTH+1 bits.
  - sum>=high_limit: output_data=high_limit, state=FALL, peak_flag=1.
  - else: output_data=sum.
- Update in FALL:
  - value-low_limit<=step (underflow-safe compare): output_data=low_limit, trough_flag=1, period_cnt+1.
  - If num_periods!=0 and period_cnt+1==num_periods: state=IDLE, busy=0, done=1 (same cycle as trough_flag).
  - Else state=RISE.
  - Otherwise (not at trough): output_data=value-step.
- sample_strobe pulses on every update, including saturated ones.
- Peak and trough are each emitted once and held one hold interval; the first value after a turnaround is high_limit-step (or low_limit+step), saturated at the opposite limit.
- Free-run (num_periods=0): period_cnt wraps modulo 2^PERIOD_W; done never asserts.
- In IDLE, output_data keeps its last value.
- All outputs are registered; latency from update decision to output is 0 cycles beyond the clock edge.

Decomposition:
- Shared package tsg_pkg: state encoding localparams (IDLE/RISE/FALL) and default widths WIDTH=16, HOLD_W=16, PERIOD_W=8.
- One sub-module, hold_timer: a programmable prescaler with inputs clk, reset, run (busy&enable), clear and hold_cycles, and output tick. It performs the 0→1 clamp.
- All other logic lives in the top-level FSM.

Test Plan:
- low=0, high=19, step=1, hold=20, periods=1, start at edge k:
  - output_data=0 after k; 1 after k+20; 19 with peak_flag after k+380; 18 after k+400.
  - 0 with trough_flag and done after k+760; busy falls at the same edge.
- Saturation, low=0, high=20, step=7, hold=1, periods=1: sequence 0,7,14,20(peak),13,6,0(trough,done), one value per clock.
- Invalid start, low=5, high=5 (and separately step=0): config_error pulses once, busy stays 0, output_data unchanged. Also: hold=0 behaves identically to hold=1.
- Pause, with enable=0 for 50 cycles mid-RISE: output_data, hold_cnt and state frozen, no strobes. After release, the remaining hold interval completes with no skipped or duplicated samples.
- Free-run and restart, periods=0 for 3 full periods: three trough_flags, no done. Then assert reset mid-FALL: all outputs immediately 0, state IDLE. A fresh start after reset then runs correctly.
- Busy-start and limits:
  - start pulsed while busy is ignored.
  - low=0xFFF0, high=0xFFFF, step=0x10: output goes 0xFFF0, then 0xFFFF (peak, no wrap), then 0xFFF0 (trough).
